// File: rtl/jk_pkg.sv
// Shared definitions for the jk_cmd_seq command sequencer: JK operation codes and FSM states.
package jk_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } jk_state_e;

  // Next value of a JK flip-flop given its current value and the {j,k} pair.
  function automatic logic jk_next(input logic q, input logic [1:0] jk);
    logic r;
    r = q;
    case (jk)
      JK_CLR:  r = 1'b0;
      JK_SET:  r = 1'b1;
      JK_TGL:  r = ~q;
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO with separate occupancy counter so full and empty are distinct.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  // Head entry is read straight from the array so a pop can load it on the same edge.
  assign rd_data = mem_q[rd_ptr_q];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/jk_cmd_seq.sv
// JK command sequencer: buffers {op,rpt} commands and drives registered j/k one op per clock.
// Define JK_CMD_SEQ_RPT_EN to honour cmd_rpt; otherwise every command issues exactly one cycle.
module jk_cmd_seq
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [CNT_W-1:0]       cmd_rpt,
  output logic                   j,
  output logic                   k,
  output logic                   busy,
  output logic                   q_model,
  output logic [$clog2(DEPTH):0] fifo_level
);

`ifdef JK_CMD_SEQ_RPT_EN
  localparam int ENT_W = 2 + CNT_W;
`else
  localparam int ENT_W = 2;
`endif

  logic [ENT_W-1:0] wr_data, rd_data;
  logic             fifo_full, fifo_empty, pop;
  logic [1:0]       rd_op;
  logic             take;

  jk_state_e state_q, state_d;
  logic      j_q, j_d, k_q, k_d, busy_q, busy_d, q_model_q, q_model_d;

`ifdef JK_CMD_SEQ_RPT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rd_cnt;
  assign wr_data = {cmd_op, cmd_rpt};
  assign rd_cnt  = rd_data[CNT_W-1:0];
`else
  logic unused_rpt;
  assign unused_rpt = ^cmd_rpt;
  assign wr_data    = cmd_op;
`endif

  assign rd_op = rd_data[ENT_W-1 -: 2];

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (cmd_valid),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign cmd_ready = ~fifo_full;
  assign pop       = take;

  // A new command is taken when idle or when the current one issues its last cycle.
  always_comb begin
    take = 1'b0;
    if (!fifo_empty) begin
      if (state_q == ST_IDLE) begin
        take = 1'b1;
      end else begin
`ifdef JK_CMD_SEQ_RPT_EN
        take = (cnt_q == '0);
`else
        take = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    k_d       = k_q;
    busy_d    = busy_q;
    q_model_d = jk_next(q_model_q, {j_q, k_q});
`ifdef JK_CMD_SEQ_RPT_EN
    cnt_d     = cnt_q;
`endif
    if (take) begin
      {j_d, k_d} = rd_op;
      busy_d     = 1'b1;
      state_d    = ST_ISSUE;
`ifdef JK_CMD_SEQ_RPT_EN
      cnt_d      = rd_cnt;
    end else if (state_q == ST_ISSUE && cnt_q != '0) begin
      cnt_d      = cnt_q - CNT_W'(1);
`endif
    end else begin
      {j_d, k_d} = JK_HOLD;
      busy_d     = 1'b0;
      state_d    = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
      busy_q    <= 1'b0;
      q_model_q <= 1'b0;
`ifdef JK_CMD_SEQ_RPT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      q_model_q <= q_model_d;
`ifdef JK_CMD_SEQ_RPT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign j       = j_q;
  assign k       = k_q;
  assign busy    = busy_q;
  assign q_model = q_model_q;

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Self-checking bench for jk_cmd_seq: vector table, hand sequences and randomized run against a queue model.
module tb_jk_cmd_seq;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
`ifdef JK_CMD_SEQ_RPT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_rpt;
  logic             j, k, busy, q_model;
  logic [2:0]       fifo_level;
  logic             q_ff;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jk_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rpt    (cmd_rpt),
    .j          (j),
    .k          (k),
    .busy       (busy),
    .q_model    (q_model),
    .fifo_level (fifo_level)
  );

  // Stand-in for the downstream jk_ff stage.
  always @(posedge clk or posedge reset) begin
    if (reset) q_ff <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   q_ff <= 1'b0;
        2'b10:   q_ff <= 1'b1;
        2'b11:   q_ff <= ~q_ff;
        default: q_ff <= q_ff;
      endcase
    end
  end

  // Reference model: pending commands in a queue, the active one as an op plus cycles left.
  typedef struct {
    logic [1:0] op;
    int         rpt;
  } cmd_t;

  cmd_t       m_fifo[$];
  bit         m_iss;
  logic [1:0] m_op;
  int         m_left;
  logic       m_q;

  task automatic model_reset();
    m_fifo.delete();
    m_iss  = 1'b0;
    m_op   = 2'b00;
    m_left = 0;
    m_q    = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] rpt);
    bit   acc;
    cmd_t c;
    acc = v && (m_fifo.size() < DEPTH);
    if (m_iss) begin
      if (m_op == 2'b01) m_q = 1'b0;
      else if (m_op == 2'b10) m_q = 1'b1;
      else if (m_op == 2'b11) m_q = ~m_q;
    end
    if (m_iss && m_left > 0) begin
      m_left = m_left - 1;
    end else if (m_fifo.size() > 0) begin
      c      = m_fifo.pop_front();
      m_iss  = 1'b1;
      m_op   = c.op;
      m_left = c.rpt;
    end else begin
      m_iss = 1'b0;
    end
    if (acc) begin
      c.op  = op;
      c.rpt = RPT ? int'(rpt) : 0;
      m_fifo.push_back(c);
      $display("push op=%b rpt=%0d level_after=%0d t=%0t", op, rpt, m_fifo.size(), $time);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all();
    logic [1:0] ejk;
    ejk = m_iss ? m_op : 2'b00;
    chk("j", j, ejk[1]);
    chk("k", k, ejk[0]);
    chk("busy", busy, m_iss);
    chk("q_model", q_model, m_q);
    chk("fifo_level", fifo_level, m_fifo.size());
    chk("cmd_ready", cmd_ready, m_fifo.size() < DEPTH);
    chk("q_vs_jk_ff", q_model, q_ff);
  endtask

  task automatic step(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] rpt);
    cmd_valid = v;
    cmd_op    = op;
    cmd_rpt   = rpt;
    @(posedge clk);
    model_edge(v, op, rpt);
    #1;
    chk_all();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [1:0] jk;
    logic       b;
    logic       q;
    logic [2:0] lvl;
    logic       rdy;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [1:0] rop;
    logic [3:0] rrp;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_rpt   = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_j", j, 1'b0);
    chk("rst_k", k, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_q_model", q_model, 1'b0);
    chk("rst_level", fifo_level, 3'd0);
    chk("rst_ready", cmd_ready, 1'b1);

    // Back-to-back CLR, SET, CLR with rpt 0: identical in both builds.
    tbl[0] = '{1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 3'd1, 1'b1};
    tbl[1] = '{1'b1, 2'b10, 2'b01, 1'b1, 1'b0, 3'd1, 1'b1};
    tbl[2] = '{1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 3'd1, 1'b1};
    tbl[3] = '{1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 3'd0, 1'b1};
    tbl[4] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[5] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      cmd_valid = tbl[i].v;
      cmd_op    = tbl[i].op;
      cmd_rpt   = '0;
      @(posedge clk);
      #1;
      chk("tbl_jk", {j, k}, tbl[i].jk);
      chk("tbl_busy", busy, tbl[i].b);
      chk("tbl_q", q_model, tbl[i].q);
      chk("tbl_level", fifo_level, tbl[i].lvl);
      chk("tbl_ready", cmd_ready, tbl[i].rdy);
    end

`ifdef JK_CMD_SEQ_RPT_EN
    // SET(rpt 0) then TGL(rpt 2).
    do_reset();
    begin
      logic [1:0] ejk[6] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
      logic       eq[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      step(1'b1, 2'b10, 4'd0);
      for (int i = 0; i < 6; i++) begin
        if (i == 0) step(1'b1, 2'b11, 4'd2);
        else        step(1'b0, 2'b00, 4'd0);
        chk("settgl_jk", {j, k}, ejk[i]);
        chk("settgl_q", q_model, eq[i]);
      end
    end

    // Fill behind a long command: level 4, fifth refused, ready back after the pop.
    do_reset();
    step(1'b1, 2'b10, 4'd15);
    for (int e = 2; e <= 18; e++) begin
      step(1'b1, 2'b01, 4'd0);
      if (e == 5)  chk("full_level", fifo_level, 3'd4);
      if (e == 5)  chk("full_ready", cmd_ready, 1'b0);
      if (e == 17) chk("full_hold_level", fifo_level, 3'd4);
      if (e == 18) chk("full_pop_level", fifo_level, 3'd3);
      if (e == 18) chk("full_pop_ready", cmd_ready, 1'b1);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 2'b00, 4'd0);
`else
    // TGL with rpt 7 issues a single cycle.
    do_reset();
    begin
      logic [1:0] ejk[3] = '{2'b11, 2'b00, 2'b00};
      logic       eq[3]  = '{1'b0, 1'b1, 1'b1};
      step(1'b1, 2'b11, 4'd7);
      for (int i = 0; i < 3; i++) begin
        step(1'b0, 2'b00, 4'd0);
        chk("tgl1_jk", {j, k}, ejk[i]);
        chk("tgl1_q", q_model, eq[i]);
      end
    end
`endif

    // Pointer wrap: ten fill/drain rounds.
    do_reset();
    for (int r = 0; r < 10; r++) begin
      step(1'b1, 2'b11, 4'd6);
      for (int i = 0; i < 4; i++) begin
        rop = 2'($urandom_range(0, 3));
        rrp = 4'($urandom_range(0, 2));
        step(1'b1, rop, rrp);
      end
      for (int i = 0; i < 24; i++) step(1'b0, 2'b00, 4'd0);
    end

    // Asynchronous reset in the middle of an issue with entries queued.
    do_reset();
    step(1'b1, 2'b10, 4'd15);
    step(1'b1, 2'b11, 4'd0);
    step(1'b1, 2'b01, 4'd0);
    step(1'b1, 2'b10, 4'd0);
    step(1'b0, 2'b00, 4'd0);
    step(1'b0, 2'b00, 4'd0);
`ifdef JK_CMD_SEQ_RPT_EN
    chk("pre_rst_level", fifo_level, 3'd3);
    chk("pre_rst_q", q_model, 1'b1);
`endif
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_j", j, 1'b0);
    chk("midrst_k", k, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_q", q_model, 1'b0);
    chk("midrst_level", fifo_level, 3'd0);
    chk("midrst_ready", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 4'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rop = 2'($urandom_range(0, 3));
      rrp = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), rop, rrp);
    end
    for (int i = 0; i < 80; i++) step(1'b0, 2'b00, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
